// File: rtl/mure_pkg.sv
// Shared types for the multiple-retirement front end.
package mure_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    POP   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mure_lane_ffs.sv
// Lowest-set-bit finder: index of the lowest set bit of vec_i plus a none-set flag.
// Purely combinational, zero latency, no flow control.
module mure_lane_ffs #(
  parameter int W  = 2,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign none_o = ~|vec_i;

endmodule

// File: rtl/retire_lane_scheduler.sv
// Walks the valid lanes of the FIFO head row in order, truncating after a trap lane, then pops the row.
// First select 1 cycle after capture, k+2 cycles per k-lane row; stalls on sink_ready_i; stats under MURE_SCHED_STATS_EN.
module retire_lane_scheduler
  import mure_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int N     = 1,
  parameter int SEL_W = $clog2(NRET),
  parameter int CNT_W = $clog2(NRET + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             row_empty_i,
  input  logic [NRET-1:0]  lane_valid_i,
  input  logic [NRET-1:0]  lane_special_i,
  input  logic [NRET-1:0]  lane_trap_i,
  input  logic             sink_ready_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             sel_valid_o,
  output logic             pop_o,
  output logic [CNT_W-1:0] nblocks_o,
  output logic [CNT_W-1:0] dropped_o,
  output logic             row_info_valid_o,
  output logic             err_o
`ifdef MURE_SCHED_STATS_EN
  ,
  output logic [31:0]      rows_o,
  output logic [31:0]      stall_cycles_o,
  output logic [31:0]      dropped_total_o
`endif
);

  sched_state_e     state_q;
  logic [NRET-1:0]  pending_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] nblocks_q;
  logic [CNT_W-1:0] dropped_q;
  logic             info_q;
  logic             err_q;

  logic [NRET-1:0]  trap_vec;
  logic [SEL_W-1:0] trap_idx;
  logic             trap_none;
  logic [NRET-1:0]  keep;
  logic [NRET-1:0]  pending_rem;
  logic [NRET-1:0]  next_src;
  logic [SEL_W-1:0] next_idx;
  logic             next_none;
  logic [CNT_W-1:0] nblk_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             over_n;

  assign trap_vec = lane_trap_i & lane_valid_i;

  mure_lane_ffs #(.W(NRET), .IW(SEL_W)) u_trap_ffs (
    .vec_i  (trap_vec),
    .idx_o  (trap_idx),
    .none_o (trap_none)
  );

  // Lanes above the first trapping lane never retire with this row.
  always_comb begin
    keep = '0;
    for (int i = 0; i < NRET; i++) begin
      keep[i] = lane_valid_i[i] & (trap_none | (i <= int'(trap_idx)));
    end
  end

  assign pending_rem = pending_q & ~(NRET'(1) << sel_q);
  assign next_src    = (state_q == IDLE) ? keep : pending_rem;

  mure_lane_ffs #(.W(NRET), .IW(SEL_W)) u_next_ffs (
    .vec_i  (next_src),
    .idx_o  (next_idx),
    .none_o (next_none)
  );

  always_comb begin
    nblk_cnt = '0;
    drop_cnt = '0;
    for (int i = 0; i < NRET; i++) begin
      nblk_cnt = nblk_cnt + CNT_W'(keep[i] & lane_special_i[i]);
      drop_cnt = drop_cnt + CNT_W'(lane_valid_i[i] & ~keep[i]);
    end
  end

  assign over_n = int'(nblk_cnt) > N;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      nblocks_q <= '0;
      dropped_q <= '0;
      info_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      info_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!row_empty_i) begin
            pending_q <= keep;
            nblocks_q <= nblk_cnt;
            dropped_q <= drop_cnt;
            info_q    <= 1'b1;
            if (over_n) err_q <= 1'b1;
            if (next_none) begin
              state_q <= POP;
            end else begin
              sel_q   <= next_idx;
              state_q <= SERVE;
            end
          end
        end
        SERVE: begin
          if (sink_ready_i) begin
            pending_q <= pending_rem;
            if (next_none) begin
              state_q <= POP;
            end else begin
              sel_q <= next_idx;
            end
          end
        end
        POP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_o            = sel_q;
  assign sel_valid_o      = (state_q == SERVE);
  assign pop_o            = (state_q == POP);
  assign nblocks_o        = nblocks_q;
  assign dropped_o        = dropped_q;
  assign row_info_valid_o = info_q;
  assign err_o            = err_q;

`ifdef MURE_SCHED_STATS_EN
  logic [31:0] rows_q;
  logic [31:0] stall_q;
  logic [31:0] drop_tot_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_q     <= '0;
      stall_q    <= '0;
      drop_tot_q <= '0;
    end else begin
      if (state_q == POP) rows_q <= rows_q + 32'd1;
      if (state_q == SERVE && !sink_ready_i) stall_q <= stall_q + 32'd1;
      if (state_q == IDLE && !row_empty_i) drop_tot_q <= drop_tot_q + 32'(drop_cnt);
    end
  end

  assign rows_o          = rows_q;
  assign stall_cycles_o  = stall_q;
  assign dropped_total_o = drop_tot_q;
`endif

endmodule

// File: tb/tb_retire_lane_scheduler.sv
// Bench for retire_lane_scheduler: directed rows, a mid-row reset, then random rows against a lane-queue model.
module tb_retire_lane_scheduler;

  localparam int NRET  = 2;
  localparam int N     = 1;
  localparam int SEL_W = 1;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             row_empty;
  logic [NRET-1:0]  lane_valid;
  logic [NRET-1:0]  lane_special;
  logic [NRET-1:0]  lane_trap;
  logic             sink_ready;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             pop;
  logic [CNT_W-1:0] nblocks;
  logic [CNT_W-1:0] dropped;
  logic             info_valid;
  logic             err;
`ifdef MURE_SCHED_STATS_EN
  logic [31:0]      rows;
  logic [31:0]      stall_cycles;
  logic [31:0]      dropped_total;
`endif

  always #5 clk = ~clk;

  retire_lane_scheduler #(.NRET(NRET), .N(N)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .row_empty_i      (row_empty),
    .lane_valid_i     (lane_valid),
    .lane_special_i   (lane_special),
    .lane_trap_i      (lane_trap),
    .sink_ready_i     (sink_ready),
    .sel_o            (sel),
    .sel_valid_o      (sel_valid),
    .pop_o            (pop),
    .nblocks_o        (nblocks),
    .dropped_o        (dropped),
    .row_info_valid_o (info_valid),
    .err_o            (err)
`ifdef MURE_SCHED_STATS_EN
    ,
    .rows_o           (rows),
    .stall_cycles_o   (stall_cycles),
    .dropped_total_o  (dropped_total)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  bit err_m   = 1'b0;
  int rows_m  = 0;
  int stall_m = 0;
  int drop_m  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_stats();
`ifdef MURE_SCHED_STATS_EN
    check("rows_o", rows, 32'(rows_m));
    check("stall_cycles_o", stall_cycles, 32'(stall_m));
    check("dropped_total_o", dropped_total, 32'(drop_m));
`endif
  endtask

  // Presents one row, then follows it cycle by cycle until it is popped.
  task automatic run_row(input logic [NRET-1:0] v, input logic [NRET-1:0] s,
                         input logic [NRET-1:0] t, input bit rnd, input logic [7:0] pat);
    int q[$];
    int nblk = 0;
    int drop = 0;
    bit hit  = 1'b0;
    bit done = 1'b0;
    bit r;
    for (int i = 0; i < NRET; i++) begin
      if (v[i]) begin
        if (hit) drop++;
        else begin
          q.push_back(i);
          if (s[i]) nblk++;
          if (t[i]) hit = 1'b1;
        end
      end
    end
    if (nblk > N) err_m = 1'b1;

    row_empty    = 1'b0;
    lane_valid   = v;
    lane_special = s;
    lane_trap    = t;
    @(posedge clk); #1;
    row_empty = 1'b1;

    for (int c = 0; c < 40 && !done; c++) begin
      r = rnd ? ($urandom_range(0, 3) != 0) : ((c < 8) ? pat[c] : 1'b1);
      sink_ready = r;
      @(negedge clk);
      if (c == 0) begin
        check("row_info_valid", 32'(info_valid), 32'd1);
        check("nblocks", 32'(nblocks), 32'(nblk));
        check("dropped", 32'(dropped), 32'(drop));
        check("err", 32'(err), 32'(err_m));
      end else begin
        check("row_info_pulse", 32'(info_valid), 32'd0);
      end
      if (q.size() != 0) begin
        check("sel_valid", 32'(sel_valid), 32'd1);
        check("sel", 32'(sel), 32'(q[0]));
        check("pop_early", 32'(pop), 32'd0);
        if (r) void'(q.pop_front());
        else stall_m++;
      end else begin
        check("pop", 32'(pop), 32'd1);
        check("sel_valid_in_pop", 32'(sel_valid), 32'd0);
        done = 1'b1;
        rows_m++;
        drop_m += drop;
      end
      @(posedge clk); #1;
    end
    if (!done) check("row_timeout", 32'd0, 32'd1);

    sink_ready = 1'b0;
    @(negedge clk);
    check("idle_sel_valid", 32'(sel_valid), 32'd0);
    check("idle_pop", 32'(pop), 32'd0);
    check("idle_err", 32'(err), 32'(err_m));
    check_stats();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_serve();
    row_empty    = 1'b0;
    lane_valid   = 2'b11;
    lane_special = 2'b00;
    lane_trap    = 2'b00;
    sink_ready   = 1'b0;
    @(posedge clk); #1;
    row_empty = 1'b1;
    @(negedge clk);
    check("pre_rst_sel_valid", 32'(sel_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    err_m = 1'b0; rows_m = 0; stall_m = 0; drop_m = 0;
    @(negedge clk);
    check("rst_sel_valid", 32'(sel_valid), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_nblocks", 32'(nblocks), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_info", 32'(info_valid), 32'd0);
    check_stats();
    @(negedge clk);
    check("rst_no_pop", 32'(pop), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst          = 1'b1;
    row_empty    = 1'b1;
    lane_valid   = '0;
    lane_special = '0;
    lane_trap    = '0;
    sink_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_sel_valid", 32'(sel_valid), 32'd0);
    check("reset_pop", 32'(pop), 32'd0);
    check("reset_info", 32'(info_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check_stats();
    @(posedge clk); #1;

    run_row(2'b11, 2'b00, 2'b00, 1'b0, 8'hFF);  // two lanes, ready high
    run_row(2'b11, 2'b01, 2'b01, 1'b0, 8'hFF);  // trap on lane 0
    run_row(2'b11, 2'b00, 2'b00, 1'b0, 8'hF8);  // three stall cycles
    run_row(2'b10, 2'b00, 2'b00, 1'b0, 8'hFF);
    run_row(2'b00, 2'b00, 2'b00, 1'b0, 8'hFF);  // bubble
    run_row(2'b11, 2'b10, 2'b10, 1'b0, 8'hFF);  // trap on last lane
    run_row(2'b11, 2'b11, 2'b00, 1'b0, 8'hFF);  // over the special limit
    run_row(2'b01, 2'b00, 2'b00, 1'b0, 8'hFF);  // error stays sticky
    reset_mid_serve();

    for (int k = 0; k < 40; k++) begin
      run_row(NRET'($urandom_range(0, 3)), NRET'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? NRET'($urandom_range(0, 3)) : NRET'(0),
              1'b1, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
